// File: rtl/aux_phase_decoder_pkg.sv
// Shared types and helpers for the auxiliary ring-oscillator phase decoder.
// Also used by the tracking-loop checker, so keep it free of design state.
package aux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    ACCUM
  } aux_state_e;

  localparam int NPH  = 7;
  localparam int NIDX = 14;

  // Odd ring taps are inverted so that a healthy ring reads as a twisted-ring code.
  function automatic logic [NPH-1:0] norm_code(input logic [NPH-1:0] s);
    return s ^ 7'b0101010;
  endfunction

  // Twisted-ring code word for index k: ones filling from n0, then zeros filling from n0.
  function automatic logic [NPH-1:0] ring_code(input int k);
    logic [NPH-1:0] c;
    c = '0;
    for (int j = 0; j < NPH; j++) begin
      c[j] = (k < NPH + 1) ? (j < k) : (j > k - (NPH + 1));
    end
    return c;
  endfunction

endpackage

// File: rtl/aux_phase_decoder_decode.sv
// Combinational decode of a normalized 7-bit twisted-ring snapshot into a phase index.
// Any word outside the 14 legal codes reports valid_o = 0 and index 0.
module aux_phase_decode
  import aux_pkg::*;
(
  input  logic [NPH-1:0] n_i,
  output logic           valid_o,
  output logic [3:0]     idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < NIDX; k++) begin
      if (n_i == ring_code(k)) begin
        valid_o = 1'b1;
        idx_o   = 4'(k);
      end
    end
  end

endmodule

// File: rtl/aux_phase_decoder.sv
// Samples the auxiliary ring phases, decodes them to 0..13, and sums unwrapped
// phase advance over 2^WIN_LOG2 samples, handing each sum out over valid/ready.
module aux_phase_decoder
  import aux_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int ACC_W    = WIN_LOG2 + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             osc_000,
  input  logic             osc_030,
  input  logic             osc_060,
  input  logic             osc_090,
  input  logic             osc_120,
  input  logic             osc_150,
  input  logic             osc_180,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [ACC_W-1:0] meas_sum,
  output logic [3:0]       phase_idx,
  output logic             code_err,
  output logic [7:0]       err_cnt,
  output logic             ovf
);

  logic [NPH-1:0]      osc_vec;
  logic [NPH-1:0]      sync1_q, sync2_q, snap_q;
  logic [NPH-1:0]      norm;
  logic                dec_valid;
  logic [3:0]          dec_idx;
  logic [3:0]          step;
  logic [ACC_W-1:0]    acc_sum;
  logic                xfer;

  aux_state_e          state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [3:0]          phase_q, phase_d;
  logic                valid_q, valid_d;
  logic [ACC_W-1:0]    sum_q, sum_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  assign osc_vec = {osc_180, osc_150, osc_120, osc_090, osc_060, osc_030, osc_000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      snap_q  <= '0;
    end else begin
      sync1_q <= osc_vec;
      sync2_q <= sync1_q;
      snap_q  <= sync2_q;
    end
  end

  assign norm = norm_code(snap_q);

  aux_phase_decode u_decode (
    .n_i     (norm),
    .valid_o (dec_valid),
    .idx_o   (dec_idx)
  );

  // Forward distance around the 14-state ring; an invalid snapshot contributes nothing.
  always_comb begin
    step = '0;
    if (dec_valid) begin
      step = (dec_idx >= phase_q) ? (dec_idx - phase_q)
                                  : (dec_idx + 4'(NIDX) - phase_q);
    end
  end

  assign acc_sum = acc_q + ACC_W'(step);
  assign xfer    = valid_q & meas_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    win_d     = win_q;
    phase_d   = phase_q;
    valid_d   = valid_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (xfer) begin
      valid_d = 1'b0;
    end

    if (!en) begin
      state_d = IDLE;
      acc_d   = '0;
      win_d   = '0;
      phase_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          acc_d   = '0;
          win_d   = '0;
          phase_d = '0;
          state_d = PRIME;
        end
        PRIME: begin
          if (dec_valid) begin
            phase_d = dec_idx;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (dec_valid) begin
            phase_d = dec_idx;
          end
          acc_d = acc_sum;
          win_d = win_q + WIN_LOG2'(1);
          // A transfer in the same cycle frees the output slot for the new sum.
          if (win_q == '1) begin
            acc_d = '0;
            if (!valid_q || xfer) begin
              sum_d   = acc_sum;
              valid_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (en && (state_q != IDLE) && !dec_valid) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      win_q     <= '0;
      phase_q   <= '0;
      valid_q   <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      win_q     <= win_d;
      phase_q   <= phase_d;
      valid_q   <= valid_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign meas_valid = valid_q;
  assign meas_sum   = sum_q;
  assign phase_idx  = phase_q;
  assign code_err   = err_q;
  assign err_cnt    = err_cnt_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_aux_phase_decoder.sv
// Directed bench for aux_phase_decoder with a window-level reference model
// checked on every cycle, plus hand-computed expectations for each scenario.
module tb_aux_phase_decoder;

  localparam int WIN_LOG2 = 4;
  localparam int ACC_W    = 8;
  localparam int WIN      = 16;
  localparam int M_IDLE   = 0;
  localparam int M_PRIME  = 1;
  localparam int M_ACCUM  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en;
  logic             meas_ready;
  logic [6:0]       oscVec;
  logic             osc_000, osc_030, osc_060, osc_090, osc_120, osc_150, osc_180;
  logic             meas_valid;
  logic [ACC_W-1:0] meas_sum;
  logic [3:0]       phase_idx;
  logic             code_err;
  logic [7:0]       err_cnt;
  logic             ovf;

  assign {osc_180, osc_150, osc_120, osc_090, osc_060, osc_030, osc_000} = oscVec;

  always #5 clk = ~clk;

  aux_phase_decoder #(.WIN_LOG2(WIN_LOG2), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .osc_000    (osc_000),
    .osc_030    (osc_030),
    .osc_060    (osc_060),
    .osc_090    (osc_090),
    .osc_120    (osc_120),
    .osc_150    (osc_150),
    .osc_180    (osc_180),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_sum   (meas_sum),
    .phase_idx  (phase_idx),
    .code_err   (code_err),
    .err_cnt    (err_cnt),
    .ovf        (ovf)
  );

  int assertCount = 0;
  int failCount   = 0;

  logic [6:0] codeTable [14];
  logic [6:0] hist [3];
  int mMode, mIdx, mAcc, mSamples, mSum, mErrCnt;
  bit mValid, mErr, mOvf;

  // rate: 0 static, 1 and 2 indices per cycle, 3 one index every four cycles
  int ringIdx, rate, subCnt;
  bit injectInvalid;

  function automatic logic [6:0] ringToOsc(input int k);
    logic [6:0] s;
    for (int i = 0; i < 7; i++) s[i] = codeTable[k][i] ^ (i % 2 == 1);
    return s;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    mMode = M_IDLE; mIdx = 0; mAcc = 0; mSamples = 0; mSum = 0; mErrCnt = 0;
    mValid = 0; mErr = 0; mOvf = 0;
  endtask

  // One clock edge of the reference: the decoded sample is the ring value from three edges ago.
  task automatic modelStep(input logic [6:0] oscNow, input bit enNow, input bit readyNow);
    logic [6:0] n;
    int found, d;
    bit xfer, oldValid;
    for (int i = 0; i < 7; i++) n[i] = hist[2][i] ^ (i % 2 == 1);
    found = -1;
    for (int k = 0; k < 14; k++) if (codeTable[k] == n) found = k;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = oscNow;
    oldValid = mValid;
    xfer = mValid && readyNow;
    if (xfer) mValid = 0;
    mErr = enNow && (mMode != M_IDLE) && (found < 0);
    if (mErr && mErrCnt < 255) mErrCnt++;
    if (!enNow) begin
      mMode = M_IDLE; mIdx = 0; mAcc = 0; mSamples = 0;
    end else begin
      case (mMode)
        M_IDLE: begin
          mMode = M_PRIME; mIdx = 0; mAcc = 0; mSamples = 0;
        end
        M_PRIME: begin
          if (found >= 0) begin mIdx = found; mMode = M_ACCUM; end
        end
        default: begin
          d = (found >= 0) ? (((found - mIdx) % 14) + 14) % 14 : 0;
          if (found >= 0) mIdx = found;
          mAcc += d;
          mSamples++;
          if (mSamples == WIN) begin
            if (!oldValid || xfer) begin mSum = mAcc; mValid = 1; end
            else mOvf = 1;
            mAcc = 0;
            mSamples = 0;
          end
        end
      endcase
    end
  endtask

  task automatic checkOutput();
    check("meas_valid", meas_valid, mValid);
    check("meas_sum", meas_sum, mSum);
    check("phase_idx", phase_idx, mIdx);
    check("code_err", code_err, mErr);
    check("err_cnt", err_cnt, mErrCnt);
    check("ovf", ovf, mOvf);
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      case (rate)
        1: ringIdx = (ringIdx + 1) % 14;
        2: ringIdx = (ringIdx + 2) % 14;
        3: begin
          subCnt++;
          if (subCnt == 4) begin subCnt = 0; ringIdx = (ringIdx + 1) % 14; end
        end
        default: ;
      endcase
      oscVec = injectInvalid ? 7'b0101111 : ringToOsc(ringIdx);
      @(posedge clk);
      modelStep(oscVec, en, meas_ready);
      @(negedge clk);
      checkOutput();
    end
  endtask

  task automatic waitSamples(input int target);
    int guard = 0;
    do begin
      applyStimulus(1);
      guard++;
    end while (!(mMode == M_ACCUM && mSamples == target) && guard < 64);
    check("window align", mSamples, target);
  endtask

  initial begin
    int held, cnt;
    for (int k = 0; k < 14; k++)
      for (int j = 0; j < 7; j++)
        codeTable[k][j] = (k < 8) ? (j < k) : (j > k - 8);
    modelReset();
    en = 0; meas_ready = 0; ringIdx = 7; rate = 0; subCnt = 0; injectInvalid = 0;
    oscVec = ringToOsc(ringIdx);

    #1 rst_n = 0;
    #2;
    check("reset meas_valid", meas_valid, 0);
    check("reset meas_sum", meas_sum, 0);
    check("reset phase_idx", phase_idx, 0);
    check("reset code_err", code_err, 0);
    check("reset err_cnt", err_cnt, 0);
    check("reset ovf", ovf, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    applyStimulus(4);

    // Static ring 1010101 reads as index 7 with zero advance.
    en = 1; meas_ready = 1;
    applyStimulus(40);
    check("static phase_idx", phase_idx, 7);
    check("static meas_sum", meas_sum, 0);

    rate = 3;
    applyStimulus(70);
    check("slow meas_sum", meas_sum, 4);
    check("slow err_cnt", err_cnt, 0);

    rate = 2; ringIdx = 10;
    applyStimulus(50);
    check("double meas_sum", meas_sum, 32);

    rate = 0;
    applyStimulus(6);
    held = ringIdx;
    injectInvalid = 1;
    applyStimulus(1);
    injectInvalid = 0;
    applyStimulus(3);
    check("invalid code_err high", code_err, 1);
    applyStimulus(1);
    check("invalid code_err low", code_err, 0);
    check("invalid err_cnt", err_cnt, 1);
    check("invalid phase_idx held", phase_idx, held);

    // Backpressure: window1 sums 16, window2 sums 0 (dropped), window3 sums 32.
    waitSamples(13); rate = 1;
    waitSamples(13); meas_ready = 0; rate = 0;
    waitSamples(13);
    check("bp first valid", meas_valid, 1);
    check("bp first sum", meas_sum, 16);
    check("bp no ovf yet", ovf, 0);
    rate = 2;
    waitSamples(13);
    check("bp ovf", ovf, 1);
    check("bp sum held", meas_sum, 16);
    check("bp valid held", meas_valid, 1);
    waitSamples(15);
    meas_ready = 1;
    applyStimulus(1);
    check("bp new sum", meas_sum, 32);
    check("bp valid stays", meas_valid, 1);

    rate = 1;
    applyStimulus(3);
    waitSamples(7);
    en = 0;
    applyStimulus(3);
    check("disable phase_idx", phase_idx, 0);
    en = 1;
    cnt = 0;
    do begin
      applyStimulus(1);
      cnt++;
    end while (!meas_valid && cnt < 40);
    check("reprime latency", cnt, 18);
    check("reprime sum", meas_sum, 16);
    check("ovf retained", ovf, 1);

    injectInvalid = 1;
    applyStimulus(260);
    injectInvalid = 0;
    check("err_cnt saturates", err_cnt, 255);
    applyStimulus(4);

    waitSamples(5);
    #3 rst_n = 0;
    #1;
    check("async meas_valid", meas_valid, 0);
    check("async meas_sum", meas_sum, 0);
    check("async phase_idx", phase_idx, 0);
    check("async code_err", code_err, 0);
    check("async err_cnt", err_cnt, 0);
    check("async ovf", ovf, 0);
    modelReset();
    en = 0;
    @(negedge clk);
    rst_n = 1;
    applyStimulus(3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/aux_phase_decoder.md
# aux_phase_decoder

Samples the seven single-ended phases of the auxiliary ring oscillator (osc_000 … osc_180) in the `clk` domain and decodes each snapshot into a 0–13 phase index. It accumulates unwrapped phase advance over a fixed window of samples and delivers one phase-sum per window over a valid/ready handshake. It sits between the auxiliary oscillator core and the low-frequency tracking loop controller, which consumes the sum as a frequency estimate.

## Interface
- `WIN_LOG2`, 8 — window length is 2^WIN_LOG2 sample cycles.
- `ACC_W`, WIN_LOG2+4 — width of the phase-sum; holds 13·2^WIN_LOG2 without overflow.
- `clk` input 1 — sampling clock; the only clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `en` input 1 — measurement enable. When low, the block returns to IDLE.
- `osc_000`, `osc_030`, `osc_060`, `osc_090`, `osc_120`, `osc_150`, `osc_180` input 1 each — ring phases s0..s6, asynchronous to `clk`.
- `meas_valid` output 1 — a phase-sum is available.
- `meas_ready` input 1 — the consumer accepts the phase-sum.
- `meas_sum` output ACC_W — accumulated phase steps for the last window.
- `phase_idx` output 4 — last valid decoded index, 0..13.
- `code_err` output 1 — pulses for one cycle when a decoded snapshot is invalid.
- `err_cnt` output 8 — count of invalid snapshots; saturates at 255.
- `ovf` output 1 — sticky; set when a window completes while `meas_valid` is still high.

## Operation
- **Synchronizer.** Each phase passes through 2 flops, then a snapshot register s[6:0].
- **Normalization.** n[i] = s[i] XOR (i odd), so n = {s0, ~s1, s2, ~s3, s4, ~s5, s6}. A healthy ring then forms a 7-bit twisted-ring code with 14 valid states.
- **Decode, k = 0..7.** n0..n(k-1) are 1 and all remaining bits are 0. Examples: 0000000→0, 1000000→1, 1111111→7.
- **Decode, k = 8..13.** n0..n(k-8) are 0 and all remaining bits are 1. Examples: 0111111→8, 0000001→13.
- **Invalid codes.** Any other code is invalid. Assert `code_err` and increment `err_cnt`. Keep `phase_idx` unchanged and use a step of 0 for that sample.
- **Step.** d = (idx_new − idx_prev) mod 14, with range 0..13. The oscillator period must exceed 14/13 sample periods. Faster rings alias, and this is not detected.
- **FSM states:**
  - IDLE: accumulator, window counter and `phase_idx` are cleared. Move to PRIME when `en` = 1.
  - PRIME: wait for the first valid decode, which loads idx_prev with no accumulation. Then move to ACCUM.
  - ACCUM: on each sample, acc += d and win_cnt += 1.
- **Window end.** When win_cnt wraps from 2^WIN_LOG2−1 to 0:
  - If `meas_valid` = 0: load `meas_sum` ← acc + d and set `meas_valid`.
  - If `meas_valid` = 1: drop the result, keep the old `meas_sum`, and set `ovf`.
  - In both cases the accumulator restarts at 0 in the same cycle. Accumulation is continuous and no samples are lost between windows.
- **Handshake.** `meas_valid` falls in the cycle after `meas_valid` & `meas_ready`. If the transfer and a new window end fall in the same cycle, the new result is loaded, `meas_valid` stays 1, and `ovf` is not set.
- **`en` low.** Dropping `en` in any state goes to IDLE the next cycle and discards any partial window. `meas_valid`, `meas_sum`, `err_cnt` and `ovf` are retained; only reset clears them.
- **Reset values.** All outputs are 0, the FSM is in IDLE, and the synchronizers are 0.

## Timing
- Oscillator edge → snapshot register: 2–3 `clk` cycles.
- Snapshot → `phase_idx` and `code_err`: +1 cycle, from the registered decode.
- Last sample of a window → `meas_valid` high: 1 cycle after its decode.
- The first window starts on the sample after the PRIME load. The first `meas_valid` appears 2^WIN_LOG2 + 1 cycles after the PRIME exit.
- Reset is asynchronous on assertion. Deassertion is handled externally, synchronized to `clk`.

## Structure
- Shared package `aux_pkg`:
  - FSM state enum {IDLE, PRIME, ACCUM}
  - constant NPH = 7
  - constant NIDX = 14
  - function `norm_code`
- Sub-module `aux_phase_decode`: combinational n[6:0] → {valid, idx[3:0]}. It is reused by the tracking-loop checker.
- The top level holds the synchronizers, the step/accumulate datapath, the FSM and the handshake.

## Test plan
- **Static ring.** Hold s = 1010101 (n = 1111111) with `en` = 1, WIN_LOG2 = 4. Expect `phase_idx` = 7 and `meas_sum` = 0 every 16 samples.
- **Slow rotation.** Advance the code by one index every 4 clk cycles, wrapping 13→0, WIN_LOG2 = 4. Expect `meas_sum` = 4 per window and no `code_err`.
- **Two steps per sample.** Step +2 indices per clk cycle, crossing 12→0. Expect d = 2 including the wrap and `meas_sum` = 32 for WIN_LOG2 = 4.
- **Invalid code.** Inject n = 1010000 for one sample. Expect a one-cycle `code_err`, `err_cnt` = 1, `phase_idx` held, and that sample adding 0 to the sum.
- **Backpressure.** Hold `meas_ready` = 0 across two window ends. Expect the first `meas_sum` held, `ovf` = 1, and `meas_valid` high. Then raise `meas_ready` in the same cycle as the third window end: expect the new sum loaded and `meas_valid` still 1.
- **Disable and reset mid-window.**
  - Drop `en` mid-window, then re-raise it. Expect PRIME again and a full window before the next `meas_valid`.
  - Assert `rst_n` = 0 mid-window. Expect all outputs 0 immediately, without waiting for a clock edge.
